down_counter: RTL and testbench

Loadable down-counter/timer: the counterpart of the team's free-running up-counter.
- The up-counter counts from zero and flags when it reaches its top value.
- This block accepts a start value over a valid/ready load handshake, counts it down to zero under an enable, and pulses `done` on reaching zero.
- It supports one-shot and auto-reload (periodic tick) modes, plus an abort.
- It is the timing source for delays and timeouts in the surrounding datapath.

---
 rtl/down_counter.sv | 113 +++++++++++
 tb/tb_down_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
//==============================================================================
// down_counter : loadable down-counter/timer, one-shot or auto-reload mode
// Revision     : 1.0
//==============================================================================
`default_nettype none

module down_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_value,
    input  logic         auto_reload,
    input  logic         en,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         done,
    output logic         busy
);

    localparam logic [N-1:0] c_zero = '0;
    localparam logic [N-1:0] c_one  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_count;
    logic [N-1:0] w_count_next;
    logic [N-1:0] r_reload;
    logic [N-1:0] w_reload_next;
    logic         r_mode;
    logic         w_mode_next;
    logic         r_done;
    logic         w_done_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= c_zero;
            r_reload <= c_zero;
            r_mode   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_reload <= w_reload_next;
            r_mode   <= w_mode_next;
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_reload_next = r_reload;
        w_mode_next   = r_mode;
        w_done_next   = 1'b0;

        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_count_next  = load_value;
                    w_reload_next = load_value;
                    w_mode_next   = auto_reload;
                    // A zero start value completes immediately without running.
                    if (load_value == c_zero) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                    w_count_next = c_zero;
                end else if (en) begin
                    if (r_count > c_one) begin
                        w_count_next = r_count - c_one;
                    end else if (r_count == c_one) begin
                        w_done_next = 1'b1;
                        if (r_mode) begin
                            w_count_next = r_reload;
                        end else begin
                            w_count_next = c_zero;
                            w_state_next = IDLE;
                        end
                    end else begin
                        // Unreachable zero count in RUN: recover quietly to IDLE.
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state == RUN);
    assign count      = r_count;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
//==============================================================================
// tb_down_counter : directed stimulus with a behavioural timer model
// Revision        : 1.0
//==============================================================================
`default_nettype none

module tb_down_counter;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [3:0] load_value;
    logic       auto_reload;
    logic       en;
    logic       abort;
    logic [3:0] count;
    logic       done;
    logic       busy;

    int total;
    int bad;
    bit check_en;

    // Behavioural model: a timer that is either running or not.
    bit m_running;
    bit m_periodic;
    int m_count;
    int m_period;
    bit m_done;

    down_counter #(.N(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_value  (load_value),
        .auto_reload (auto_reload),
        .en          (en),
        .abort       (abort),
        .count       (count),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            m_running  = 1'b0;
            m_periodic = 1'b0;
            m_count    = 0;
            m_period   = 0;
            m_done     = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_running) begin
                if (load_valid) begin
                    m_count    = int'(load_value);
                    m_period   = int'(load_value);
                    m_periodic = auto_reload;
                    if (m_count == 0) m_done = 1'b1;
                    else              m_running = 1'b1;
                end
            end else if (abort) begin
                m_running = 1'b0;
                m_count   = 0;
            end else if (en) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_done = 1'b1;
                    if (m_periodic) m_count = m_period;
                    else            m_running = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            total = total + 4;
            if (count !== 4'(m_count)) begin
                bad++;
                $display("FAIL model_count t=%0t got=%0d want=%0d", $time, count, m_count);
            end
            if (done !== m_done) begin
                bad++;
                $display("FAIL model_done t=%0t got=%0b want=%0b", $time, done, m_done);
            end
            if (busy !== m_running) begin
                bad++;
                $display("FAIL model_busy t=%0t got=%0b want=%0b", $time, busy, m_running);
            end
            if (load_ready !== !m_running) begin
                bad++;
                $display("FAIL model_ready t=%0t got=%0b want=%0b", $time, load_ready, !m_running);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic expect_out(input string name, input int c, input bit d, input bit b);
        lit({name, "_count"}, 32'(count), 32'(c));
        lit({name, "_done"},  32'(done),  32'(d));
        lit({name, "_busy"},  32'(busy),  32'(b));
        lit({name, "_ready"}, 32'(load_ready), 32'(!b));
    endtask

    task automatic load(input int l, input bit ar);
        load_valid  = 1'b1;
        load_value  = 4'(l);
        auto_reload = ar;
        tick();
        load_valid  = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; check_en = 1'b0;
        reset = 1'b0; load_valid = 1'b1; load_value = 4'd9;
        auto_reload = 1'b0; en = 1'b1; abort = 1'b0;

        // Reset held for two edges with a load offered, which must be ignored.
        tick();
        check_en = 1'b1;
        tick();
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        expect_out("reset", 0, 1'b0, 1'b0);

        // One-shot L=5: count 5..0, done only in the zero cycle.
        load(5, 1'b0);
        expect_out("os_load", 5, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            tick();
            expect_out("os_run", 5 - j, j == 5, j < 5);
        end

        // Auto-reload L=3 for 10 cycles, then abort.
        load(3, 1'b1);
        expect_out("ar_load", 3, 1'b0, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            expect_out("ar_run", ((j % 3) == 0) ? 3 : 3 - (j % 3), (j % 3) == 0, 1'b1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("ar_abort", 0, 1'b0, 1'b0);

        // Enable gap of two cycles at count=2 delays done by two cycles.
        load(4, 1'b0);
        tick(); tick();
        expect_out("gap_pre", 2, 1'b0, 1'b1);
        en = 1'b0;
        tick(); tick();
        expect_out("gap_hold", 2, 1'b0, 1'b1);
        en = 1'b1;
        tick();
        expect_out("gap_one", 1, 1'b0, 1'b1);
        tick();
        expect_out("gap_done", 0, 1'b1, 1'b0);

        // Abort at count=1 with en=1 beats the zero event.
        load(4, 1'b0);
        tick(); tick(); tick();
        expect_out("ab_pre", 1, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("ab_post", 0, 1'b0, 1'b0);
        tick();
        expect_out("ab_after", 0, 1'b0, 1'b0);

        // L=0 completes at once and never enters RUN.
        load_value = 4'd7;
        tick();
        load(0, 1'b1);
        expect_out("zero_load", 0, 1'b1, 1'b0);
        tick();
        expect_out("zero_after", 0, 1'b0, 1'b0);

        // L=15 with a load offered mid-run, then a back-to-back load on done.
        load(15, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            if (j == 5) begin
                load_valid = 1'b1;
                load_value = 4'd7;
            end
            if (j == 8) load_valid = 1'b0;
            tick();
            expect_out("max_run", 15 - j, j == 15, j < 15);
        end
        load(2, 1'b0);
        expect_out("b2b_load", 2, 1'b0, 1'b1);
        tick();
        tick();
        expect_out("b2b_done", 0, 1'b1, 1'b0);

        // Reset at count=4 during an L=8 run.
        load(8, 1'b0);
        for (int j = 1; j <= 4; j++) tick();
        expect_out("rst_pre", 4, 1'b0, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_out("rst_post", 0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            tick();
            lit("rst_nodone", 32'(done), 32'd0);
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
